// File: rtl/alu_seq_ctrl.sv
// Issue-side sequencer for the 8-bit combinational ALU: owns a small operand
// register file, drives a/b/sel from registers and returns z over a response channel.
module alu_seq_ctrl #(
  parameter int WIDTH = 8,
  parameter int AW    = 2,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [AW-1:0]    cmd_dst,
  input  logic [AW-1:0]    cmd_srca,
  input  logic [AW-1:0]    cmd_srcb,
  input  logic             ld_en,
  input  logic [AW-1:0]    ld_addr,
  input  logic [WIDTH-1:0] ld_data,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_sel,
  input  logic [WIDTH-1:0] alu_z,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [CNTW-1:0]  op_count
);

  localparam int NREG = 1 << AW;
  localparam logic [3:0] OP_UNDEF = 4'b1111;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_RESP
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_rf [NREG];
  logic [WIDTH-1:0] w_rf_next [NREG];
  logic [AW-1:0]    r_dst;
  logic [WIDTH-1:0] r_alu_a;
  logic [WIDTH-1:0] r_alu_b;
  logic [3:0]       r_alu_sel;
  logic [WIDTH-1:0] r_rsp_data;
  logic             r_rsp_zero;
  logic             r_rsp_err;
  logic [CNTW-1:0]  r_op_count;

  logic             w_accept;
  logic             w_wb_en;
  logic             w_rsp_fire;
  logic [WIDTH-1:0] w_result;

  assign cmd_ready  = rst_n && (r_state == S_IDLE);
  assign rsp_valid  = (r_state == S_RESP);
  assign w_accept   = cmd_valid && cmd_ready;
  assign w_rsp_fire = (r_state == S_RESP) && rsp_ready;

  // The undefined opcode produces no write-back and reports a zero result.
  assign w_wb_en  = (r_state == S_EXEC) && (r_alu_sel != OP_UNDEF);
  assign w_result = (r_alu_sel == OP_UNDEF) ? '0 : alu_z;

  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign alu_sel  = r_alu_sel;
  assign rsp_data = r_rsp_data;
  assign rsp_zero = r_rsp_zero;
  assign rsp_err  = r_rsp_err;
  assign op_count = r_op_count;

  // Direct loads take priority over a same-edge write-back to the same register.
  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_rf
      logic w_ld_hit;
      logic w_wb_hit;
      assign w_ld_hit      = ld_en && (ld_addr == AW'(gi));
      assign w_wb_hit      = w_wb_en && (r_dst == AW'(gi));
      assign w_rf_next[gi] = w_ld_hit ? ld_data : (w_wb_hit ? alu_z : r_rf[gi]);
    end
  endgenerate

  always_ff @(posedge clk) begin
    for (int i = 0; i < NREG; i++) begin
      if (!rst_n) begin
        r_rf[i] <= '0;
      end else begin
        r_rf[i] <= w_rf_next[i];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_dst      <= '0;
      r_alu_a    <= '0;
      r_alu_b    <= '0;
      r_alu_sel  <= '0;
      r_rsp_data <= '0;
      r_rsp_zero <= 1'b0;
      r_rsp_err  <= 1'b0;
      r_op_count <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          // Operands come from the file as it stood before this edge.
          if (w_accept) begin
            r_alu_a   <= r_rf[cmd_srca];
            r_alu_b   <= r_rf[cmd_srcb];
            r_alu_sel <= cmd_op;
            r_dst     <= cmd_dst;
            r_state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_rsp_data <= w_result;
          r_rsp_zero <= (w_result == '0);
          r_rsp_err  <= (r_alu_sel == OP_UNDEF);
          r_state    <= S_RESP;
        end
        S_RESP: begin
          if (w_rsp_fire) begin
            r_op_count <= r_op_count + CNTW'(1);
            r_state    <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Bench for alu_seq_ctrl: hosts a behavioural ALU, runs directed and random
// command sequences and checks every handshake against a register-file model.
module tb_alu_seq_ctrl;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] cmd_op;
  logic [1:0] cmd_dst;
  logic [1:0] cmd_srca;
  logic [1:0] cmd_srcb;
  logic       ld_en;
  logic [1:0] ld_addr;
  logic [7:0] ld_data;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [3:0] alu_sel;
  logic [7:0] alu_z;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_data;
  logic       rsp_zero;
  logic       rsp_err;
  logic [15:0] op_count;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_txn  = 0;

  logic [7:0]  ref_rf [4];
  logic [15:0] ref_count;

  alu_seq_ctrl #(.WIDTH(8), .AW(2), .CNTW(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_dst(cmd_dst), .cmd_srca(cmd_srca), .cmd_srcb(cmd_srcb),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_z(alu_z),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_zero(rsp_zero), .rsp_err(rsp_err), .op_count(op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the team ALU; opcode 1111 returns junk the controller must discard.
  function automatic logic [7:0] alu_f(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] p;
    p = 16'(a) * 16'(b);
    case (op)
      4'h0: return a + b;
      4'h1: return a - b;
      4'h2: return b - a;
      4'h3: return p[7:0];
      4'h4: return a << 1;
      4'h5: return a >> 1;
      4'h6: return ~a;
      4'h7: return a + 8'd1;
      4'h8: return a & b;
      4'h9: return a | b;
      4'hA: return a ^ b;
      4'hB: return ~(a & b);
      4'hC: return (a == b) ? 8'd1 : 8'd0;
      4'hD: return (a < b) ? 8'd1 : 8'd0;
      4'hE: return b;
      default: return 8'hEE;
    endcase
  endfunction

  assign alu_z = alu_f(alu_sel, alu_a, alu_b);

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_ld(input logic [1:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    tick;
    ld_en = 1'b0;
    ref_rf[a] = d;
  endtask

  task automatic ref_reset;
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_count = 16'd0;
  endtask

  // ld_when: 0 none, 1 on the accept edge, 2 on the execute edge.
  task automatic run_op(input logic [3:0] op, input logic [1:0] dst, input logic [1:0] sa,
                        input logic [1:0] sb, input int stall, input int ld_when,
                        input logic [1:0] la, input logic [7:0] ld_d, output logic [7:0] got);
    logic [7:0] ea, eb, er;
    logic       ee;
    ea = ref_rf[sa];
    eb = ref_rf[sb];
    ee = (op == 4'hF);
    er = ee ? 8'h00 : alu_f(op, ea, eb);
    chk("cmd_ready_idle", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_dst = dst; cmd_srca = sa; cmd_srcb = sb;
    rsp_ready = (stall == 0);
    if (ld_when == 1) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
    tick;
    cmd_valid = 1'b0; ld_en = 1'b0;
    if (ld_when == 1) ref_rf[la] = ld_d;
    chk("alu_a", 32'(alu_a), 32'(ea));
    chk("alu_b", 32'(alu_b), 32'(eb));
    chk("alu_sel", 32'(alu_sel), 32'(op));
    chk("exec_busy", {cmd_ready, rsp_valid}, 32'd0);
    if (ld_when == 2) begin ld_en = 1'b1; ld_addr = la; ld_data = ld_d; end
    tick;
    ld_en = 1'b0;
    if (!ee) ref_rf[dst] = er;
    if (ld_when == 2) ref_rf[la] = ld_d;
    chk("rsp_valid", 32'(rsp_valid), 32'd1);
    chk("rsp_data", 32'(rsp_data), 32'(er));
    chk("rsp_zero", 32'(rsp_zero), 32'(er == 8'h00));
    chk("rsp_err", 32'(rsp_err), 32'(ee));
    got = rsp_data;
    for (int s = 0; s < stall; s++) begin
      cmd_valid = 1'b1; cmd_op = ~op; cmd_dst = 2'($urandom);
      cmd_srca = 2'($urandom); cmd_srcb = 2'($urandom);
      tick;
      chk("stall_valid", 32'(rsp_valid), 32'd1);
      chk("stall_data", 32'(rsp_data), 32'(er));
      chk("stall_ready", 32'(cmd_ready), 32'd0);
      chk("stall_count", 32'(op_count), 32'(ref_count));
      chk("stall_sel", 32'(alu_sel), 32'(op));
    end
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    tick;
    ref_count = ref_count + 16'd1;
    chk("op_count", 32'(op_count), 32'(ref_count));
    chk("rsp_done", {rsp_valid, cmd_ready}, 32'd1);
    chk("sel_hold", 32'(alu_sel), 32'(op));
    n_txn++;
    $display("txn %0d op=%h dst=%0d a=%h b=%h stall=%0d ld=%0d -> data=%h zero=%b err=%b cnt=%0d",
             n_txn, op, dst, ea, eb, stall, ld_when, rsp_data, rsp_zero, rsp_err, op_count);
  endtask

  initial begin
    logic [7:0] got;
    logic [3:0] rop;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 4'h0; cmd_dst = 2'd0; cmd_srca = 2'd0;
    cmd_srcb = 2'd0; ld_en = 1'b0; ld_addr = 2'd0; ld_data = 8'h00; rsp_ready = 1'b1;
    ref_reset();

    // Reset state
    tick; tick;
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("rst_outputs", {rsp_valid, rsp_zero, rsp_err, alu_sel}, 32'd0);
    chk("rst_data", {alu_a, alu_b, rsp_data}, 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", 32'(cmd_ready), 32'd1);

    // Basic add and write-back
    do_ld(2'd0, 8'h30); do_ld(2'd1, 8'h25);
    run_op(4'h0, 2'd2, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00, got);
    chk("add_const", 32'(got), 32'h55);
    chk("count_one", 32'(op_count), 32'd1);
    run_op(4'h0, 2'd3, 2'd2, 2'd0, 0, 0, 2'd0, 8'h00, got);
    chk("add_r2_const", 32'(got), 32'h85);

    // Subtract and multiply low byte
    do_ld(2'd0, 8'h10); do_ld(2'd1, 8'h20);
    run_op(4'h1, 2'd3, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00, got);
    chk("sub_const", 32'(got), 32'hF0);
    do_ld(2'd0, 8'h12); do_ld(2'd1, 8'h10);
    run_op(4'h3, 2'd3, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00, got);
    chk("mul_const", 32'(got), 32'h20);

    // Zero result, then undefined opcode leaves dst alone
    do_ld(2'd0, 8'h0F); do_ld(2'd1, 8'hF0);
    run_op(4'h8, 2'd3, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00, got);
    chk("and_zero_flag", 32'(rsp_zero), 32'd1);
    run_op(4'hF, 2'd1, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00, got);
    chk("undef_err_data", {rsp_err, got}, 32'h100);
    run_op(4'hE, 2'd2, 2'd0, 2'd1, 0, 0, 2'd0, 8'h00, got);
    chk("undef_dst_kept", 32'(got), 32'hF0);

    // Backpressure for 5 cycles
    run_op(4'h9, 2'd2, 2'd0, 2'd1, 5, 0, 2'd0, 8'h00, got);
    chk("bp_count", 32'(op_count), 32'd8);
    tick;
    chk("bp_count_once", 32'(op_count), 32'd8);

    // Same-edge ld beats write-back; ld on accept edge does not disturb operands
    do_ld(2'd0, 8'h30); do_ld(2'd1, 8'h25);
    run_op(4'h0, 2'd2, 2'd0, 2'd1, 0, 2, 2'd2, 8'hAA, got);
    chk("coll_rsp", 32'(got), 32'h55);
    run_op(4'hE, 2'd3, 2'd0, 2'd2, 0, 0, 2'd0, 8'h00, got);
    chk("coll_ld_wins", 32'(got), 32'hAA);
    run_op(4'h0, 2'd3, 2'd0, 2'd1, 0, 1, 2'd0, 8'h01, got);
    chk("acc_ld_old_a", 32'(got), 32'h55);
    run_op(4'hE, 2'd3, 2'd1, 2'd0, 0, 0, 2'd0, 8'h00, got);
    chk("acc_ld_landed", 32'(got), 32'h01);

    // Reset during EXEC
    do_ld(2'd0, 8'h11); do_ld(2'd1, 8'h22);
    cmd_valid = 1'b1; cmd_op = 4'h0; cmd_dst = 2'd3; cmd_srca = 2'd0; cmd_srcb = 2'd1;
    tick;
    cmd_valid = 1'b0; rst_n = 1'b0;
    tick;
    chk("mid_rst_valid", 32'(rsp_valid), 32'd0);
    chk("mid_rst_count", 32'(op_count), 32'd0);
    chk("mid_rst_regs", {alu_a, alu_b, rsp_data}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_idle", 32'(cmd_ready), 32'd1);
    ref_reset();

    // Back-to-back stream of 10 defined ops; first one reads r3 after reset
    run_op(4'hE, 2'd0, 2'd0, 2'd3, 0, 0, 2'd0, 8'h00, got);
    chk("mid_rst_dst_zero", 32'(got), 32'h00);
    for (int i = 1; i < 10; i++) begin
      rop = 4'($urandom_range(0, 14));
      run_op(rop, 2'($urandom), 2'($urandom), 2'($urandom), 0,
             (i % 3 == 0) ? 0 : 0, 2'd0, 8'h00, got);
      do_ld(2'($urandom), 8'($urandom));
    end
    chk("stream_count", 32'(op_count), 32'd10);

    // Randomized commands with loads, collisions and stalls
    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom);
      run_op(rop, 2'($urandom), 2'($urandom), 2'($urandom), $urandom_range(0, 3),
             $urandom_range(0, 2), 2'($urandom), 8'($urandom), got);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
